// File: rtl/am2952_ioport.sv
// am2952_ioport: synchronous bidirectional I/O port in the style of the Am2952/2953.
// Two independent holding registers, A->B (reg_ab) and B->A (reg_ba). Each register
// has a full flag for the write/acknowledge handshake and a sticky overrun flag.
//
// Parameters:
//   WIDTH     - data width of both registers and buses
//   INVERT    - 1: outputs drive the inverted register contents (Am2953), 0: true data (Am2952)
//   OVERWRITE - 1: a write into a full register replaces the data, 0: the write is dropped
//
// Ports:
//   clk, rst        - clock (rising edge) and synchronous active-high reset
//   a_in / b_in     - data arriving from the A / B bus
//   a_y / b_y       - tristate drivers onto the A bus (reg_ba) / B bus (reg_ab)
//   cea_ / ceb_     - active-low load strobes for reg_ab / reg_ba
//   oea_ / oeb_     - active-low output enables for a_y / b_y
//   ackb / acka     - the consuming side has read reg_ab / reg_ba
//   full_ab/full_ba - the register holds unread data
//   ovr_ab/ovr_ba   - sticky: a write arrived while full and not acknowledged
//   clrovr          - clears both overrun flags
//   int_            - active-low interrupt, asserted while any flag is set
module am2952_ioport #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          INVERT    = 1'b0,
  parameter bit          OVERWRITE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_in,
  output logic [WIDTH-1:0] a_y,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] b_y,
  input  logic             cea_,
  input  logic             ceb_,
  input  logic             oea_,
  input  logic             oeb_,
  input  logic             ackb,
  input  logic             acka,
  output logic             full_ab,
  output logic             full_ba,
  output logic             ovr_ab,
  output logic             ovr_ba,
  input  logic             clrovr,
  output logic             int_
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_t;

  chan_state_t      st_ab, st_ab_nxt;
  chan_state_t      st_ba, st_ba_nxt;
  logic [WIDTH-1:0] reg_ab, reg_ab_nxt;
  logic [WIDTH-1:0] reg_ba, reg_ba_nxt;
  logic             ovr_ab_nxt, ovr_ba_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_ab  <= EMPTY;
      st_ba  <= EMPTY;
      reg_ab <= '0;
      reg_ba <= '0;
      ovr_ab <= 1'b0;
      ovr_ba <= 1'b0;
    end else begin
      st_ab  <= st_ab_nxt;
      st_ba  <= st_ba_nxt;
      reg_ab <= reg_ab_nxt;
      reg_ba <= reg_ba_nxt;
      ovr_ab <= ovr_ab_nxt;
      ovr_ba <= ovr_ba_nxt;
    end
  end

  // A write in the same cycle as an ack always lands: the ack consumes the old
  // data first, so neither overrun nor the OVERWRITE drop rule applies.
  always_comb begin
    st_ab_nxt  = st_ab;
    reg_ab_nxt = reg_ab;
    if (!cea_) begin
      if (ackb || st_ab == EMPTY || OVERWRITE) reg_ab_nxt = a_in;
      st_ab_nxt = FULL;
    end else if (ackb) begin
      st_ab_nxt = EMPTY;
    end
    // Set beats clear when a new overrun coincides with clrovr.
    ovr_ab_nxt = (ovr_ab && !clrovr) || (!cea_ && st_ab == FULL && !ackb);
  end

  always_comb begin
    st_ba_nxt  = st_ba;
    reg_ba_nxt = reg_ba;
    if (!ceb_) begin
      if (acka || st_ba == EMPTY || OVERWRITE) reg_ba_nxt = b_in;
      st_ba_nxt = FULL;
    end else if (acka) begin
      st_ba_nxt = EMPTY;
    end
    ovr_ba_nxt = (ovr_ba && !clrovr) || (!ceb_ && st_ba == FULL && !acka);
  end

  assign full_ab = (st_ab == FULL);
  assign full_ba = (st_ba == FULL);
  assign int_    = ~(full_ab | full_ba | ovr_ab | ovr_ba);

  assign b_y = oeb_ ? 'z : (INVERT ? ~reg_ab : reg_ab);
  assign a_y = oea_ ? 'z : (INVERT ? ~reg_ba : reg_ba);

endmodule

// File: tb/tb_am2952_ioport.sv
module tb_am2952_ioport;

  logic       clk = 1'b0;
  logic       rst, cea_, ceb_, oea_, oeb_, ackb, acka, clrovr;
  logic [7:0] a_in, b_in;

  logic [7:0] a_y0, b_y0, a_y1, b_y1;
  logic       fab0, fba0, oab0, oba0, int0;
  logic       fab1, fba1, oab1, oba1, int1;

  always #5 clk = ~clk;

  am2952_ioport #(.WIDTH(8), .INVERT(1'b0), .OVERWRITE(1'b1)) dut0 (
    .clk(clk), .rst(rst), .a_in(a_in), .a_y(a_y0), .b_in(b_in), .b_y(b_y0),
    .cea_(cea_), .ceb_(ceb_), .oea_(oea_), .oeb_(oeb_), .ackb(ackb), .acka(acka),
    .full_ab(fab0), .full_ba(fba0), .ovr_ab(oab0), .ovr_ba(oba0),
    .clrovr(clrovr), .int_(int0)
  );

  am2952_ioport #(.WIDTH(8), .INVERT(1'b1), .OVERWRITE(1'b0)) dut1 (
    .clk(clk), .rst(rst), .a_in(a_in), .a_y(a_y1), .b_in(b_in), .b_y(b_y1),
    .cea_(cea_), .ceb_(ceb_), .oea_(oea_), .oeb_(oeb_), .ackb(ackb), .acka(acka),
    .full_ab(fab1), .full_ba(fba1), .ovr_ab(oab1), .ovr_ba(oba1),
    .clrovr(clrovr), .int_(int1)
  );

  // flags = {full_ab, full_ba, ovr_ab, ovr_ba, int_}
  typedef struct packed {
    logic [7:0] a_y;
    logic [7:0] b_y;
    logic [4:0] flags;
  } exp_t;

  typedef struct {
    logic [7:0] r;
    bit         f;
    bit         o;
  } ch_t;

  exp_t q0[$];
  exp_t q1[$];
  ch_t  m_ab[2];
  ch_t  m_ba[2];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference behaviour of one channel for one clock edge.
  function automatic ch_t step(ch_t c, bit rst_i, bit ow, bit wr, bit ack,
                               logic [7:0] din, bit clr);
    ch_t n;
    n = c;
    if (rst_i) begin
      n.r = 8'h00;
      n.f = 1'b0;
      n.o = 1'b0;
      return n;
    end
    n.o = (c.o && !clr) || (wr && c.f && !ack);
    if (wr && (ack || !c.f || ow)) n.r = din;
    if (wr) n.f = 1'b1;
    else if (ack) n.f = 1'b0;
    return n;
  endfunction

  // Advance the model with the inputs currently applied, queue the outputs
  // expected after the coming rising edge, then move on to the next falling edge.
  task automatic cyc();
    bit   ow, inv;
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      ow  = (k == 0);
      inv = (k == 1);
      m_ab[k] = step(m_ab[k], rst, ow, !cea_, ackb, a_in, clrovr);
      m_ba[k] = step(m_ba[k], rst, ow, !ceb_, acka, b_in, clrovr);
      e.a_y = oea_ ? 8'hzz : (inv ? ~m_ba[k].r : m_ba[k].r);
      e.b_y = oeb_ ? 8'hzz : (inv ? ~m_ab[k].r : m_ab[k].r);
      e.flags = {m_ab[k].f, m_ba[k].f, m_ab[k].o, m_ba[k].o,
                 !(m_ab[k].f || m_ba[k].f || m_ab[k].o || m_ba[k].o)};
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; cea_ = 1'b1; ceb_ = 1'b1;
    ackb = 1'b0; acka = 1'b0; clrovr = 1'b0;
  endtask

  // Monitor: one expected entry per DUT per clock edge once stimulus has begun.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        n_checks++;
        if ({a_y0, b_y0} !== {e.a_y, e.b_y}) begin
          n_fail++;
          $display("FAIL dut0_bus t=%0t got a_y=%h b_y=%h expected a_y=%h b_y=%h",
                   $time, a_y0, b_y0, e.a_y, e.b_y);
        end
        n_checks++;
        if ({fab0, fba0, oab0, oba0, int0} !== e.flags) begin
          n_fail++;
          $display("FAIL dut0_flags t=%0t got %b expected %b", $time,
                   {fab0, fba0, oab0, oba0, int0}, e.flags);
        end
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        n_checks++;
        if ({a_y1, b_y1} !== {e.a_y, e.b_y}) begin
          n_fail++;
          $display("FAIL dut1_bus t=%0t got a_y=%h b_y=%h expected a_y=%h b_y=%h",
                   $time, a_y1, b_y1, e.a_y, e.b_y);
        end
        n_checks++;
        if ({fab1, fba1, oab1, oba1, int1} !== e.flags) begin
          n_fail++;
          $display("FAIL dut1_flags t=%0t got %b expected %b", $time,
                   {fab1, fba1, oab1, oba1, int1}, e.flags);
        end
      end
    end
  end

  initial begin
    idle();
    oea_ = 1'b0; oeb_ = 1'b0;
    a_in = 8'h00; b_in = 8'h00;

    // Reset, with a competing load that must be ignored.
    rst = 1'b1; cea_ = 1'b0; a_in = 8'h77; cyc();
    idle(); oeb_ = 1'b1; cyc();
    oeb_ = 1'b0;

    // Basic AB transfer and ack.
    a_in = 8'hA5; cea_ = 1'b0; cyc();
    idle(); cyc();
    ackb = 1'b1; cyc();
    idle(); ackb = 1'b1; cyc();   // ack while empty
    idle(); cyc();

    // Overrun: dut0 overwrites, dut1 drops; then clear overrun.
    a_in = 8'h11; cea_ = 1'b0; cyc();
    a_in = 8'h22; cea_ = 1'b0; cyc();
    idle(); cyc();
    clrovr = 1'b1; cyc();
    idle(); cyc();

    // Write and ack together while full.
    a_in = 8'h3C; cea_ = 1'b0; ackb = 1'b1; cyc();
    idle(); cyc();

    // Overrun coinciding with clrovr: set wins.
    a_in = 8'h5A; cea_ = 1'b0; clrovr = 1'b1; cyc();
    idle(); ackb = 1'b1; clrovr = 1'b1; cyc();

    // Channel independence.
    idle(); a_in = 8'hF0; cea_ = 1'b0; cyc();
    idle(); b_in = 8'h0F; ceb_ = 1'b0; cyc();
    idle(); acka = 1'b1; cyc();
    idle(); cyc();

    // Reset in the middle of activity.
    a_in = 8'h01; b_in = 8'h02; cea_ = 1'b0; ceb_ = 1'b0; cyc();
    a_in = 8'h03; b_in = 8'h04; cea_ = 1'b0; ceb_ = 1'b0; cyc();
    idle(); rst = 1'b1; cea_ = 1'b0; a_in = 8'h77; cyc();
    idle(); cyc();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 79) == 0);
      cea_   = ($urandom_range(0, 2) != 0);
      ceb_   = ($urandom_range(0, 2) != 0);
      ackb   = ($urandom_range(0, 2) == 0);
      acka   = ($urandom_range(0, 2) == 0);
      clrovr = ($urandom_range(0, 7) == 0);
      oea_   = ($urandom_range(0, 3) == 0);
      oeb_   = ($urandom_range(0, 3) == 0);
      a_in   = 8'($urandom);
      b_in   = 8'($urandom);
      cyc();
    end

    idle();
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d/%0d pending expected 0/0", q0.size(), q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
